// File: rtl/line_clear_if.sv
// Bus between the game FSM and the line-clear sequencer.
// start is a one-cycle request, honoured only while idle; done is a one-cycle completion pulse.
interface line_clear_if #(
  parameter int ROWS = 22,
  parameter int COLS = 10,
  parameter int CW   = 3
);
  logic                                start;
  logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_i;
  logic                                busy;
  logic                                done;
  logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_o;
  logic [4:0]                          lines_o;
  logic [15:0]                         total_lines_o;

  modport master (
    output start, grid_i,
    input  busy, done, grid_o, lines_o, total_lines_o
  );

  modport slave (
    input  start, grid_i,
    output busy, done, grid_o, lines_o, total_lines_o
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans rows bottom-up, collapsing one full row per SHIFT cycle,
// then reports the compacted grid and per-pass / running clear counts.
module line_clear_ctrl #(
  parameter int ROWS = 22,
  parameter int COLS = 10,
  parameter int CW   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  line_clear_if.slave  bus,
  output logic [1:0]   fsm_state
);
  localparam int RW = $clog2(ROWS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                        state;
  logic [ROWS-1:0][COLS-1:0][CW-1:0] w;
  logic [RW-1:0]                     r;
  logic [4:0]                        pass;
  logic                              row_full;
  logic [16:0]                       sum;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (w[r][c] == '0) row_full = 1'b0;
    end
  end

  // 17-bit sum so the running total can clamp instead of wrapping.
  assign sum = {1'b0, bus.total_lines_o} + {12'd0, pass};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      w                 <= '0;
      r                 <= '0;
      pass              <= '0;
      bus.lines_o       <= '0;
      bus.total_lines_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            w     <= bus.grid_i;
            r     <= RW'(ROWS - 1);
            pass  <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (row_full) begin
            state <= S_SHIFT;
          end else if (r != '0) begin
            r <= r - 1'b1;
          end else begin
            // Results land on the same edge that raises done.
            state             <= S_DONE;
            bus.lines_o       <= pass;
            bus.total_lines_o <= sum[16] ? 16'hFFFF : sum[15:0];
          end
        end
        S_SHIFT: begin
          // Drop everything above r by one row; r is rescanned next cycle.
          for (int k = 1; k < ROWS; k++) begin
            if (RW'(k) <= r) w[k] <= w[k-1];
          end
          w[0]  <= '0;
          pass  <= pass + 1'b1;
          state <= S_SCAN;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_SCAN) || (state == S_SHIFT);
  assign bus.done   = (state == S_DONE);
  assign bus.grid_o = w;
  assign fsm_state  = state;
endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: directed table, hand sequences for reset / start-while-busy /
// saturation, and random grids checked against a row-filter reference model.
module tb_line_clear_ctrl;
  localparam int ROWS = 22;
  localparam int COLS = 10;
  localparam int CW   = 3;
  localparam int GW   = ROWS * COLS * CW;

  typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_t;
  typedef logic [COLS-1:0][CW-1:0]           row_t;
  typedef struct {
    grid_t g;
    grid_t eg;
    int    lines;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] fsm_state;
  int         tests;
  int         fails;
  int         exp_total;
  logic [GW+4:0] exp_q[$];
  vec_t       tbl[4];

  line_clear_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) bus ();

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: keep the non-full rows in bottom-up order and stack them at the bottom.
  function automatic void ref_compact(input grid_t g, output grid_t o, output int n);
    row_t kept[$];
    bit   full;
    n = 0;
    for (int rr = ROWS - 1; rr >= 0; rr--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (g[rr][c] == '0) full = 1'b0;
      if (full) n++;
      else kept.push_back(g[rr]);
    end
    o = '0;
    for (int i = 0; i < kept.size(); i++) o[ROWS-1-i] = kept[i];
  endfunction

  // ---------------- driver ----------------
  task automatic run_pass(input string tag, input grid_t g, input grid_t eg, input int el,
                          input bit intrude, input grid_t other);
    int            cyc;
    int            iters;
    int            extra;
    logic [GW+4:0] e;
    exp_q.push_back({5'(el), eg});
    @(negedge clk);
    bus.grid_i = g;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc   = 0;
    iters = 0;
    while (!bus.done && iters < 100) begin
      if (bus.busy) cyc++;
      if (intrude && iters == 4) begin
        bus.start  = 1'b1;
        bus.grid_i = other;
      end else begin
        bus.start = 1'b0;
      end
      iters++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_done_seen"}, GW'(bus.done), GW'(1));
    chk({tag, "_busy_cycles"}, GW'(cyc), GW'(22 + 2 * el));
    chk({tag, "_busy_at_done"}, GW'(bus.busy), GW'(0));
    chk({tag, "_lines"}, GW'(bus.lines_o), GW'(e[GW+4:GW]));
    chk({tag, "_grid"}, bus.grid_o, e[GW-1:0]);
    exp_total = (exp_total + el > 65535) ? 65535 : exp_total + el;
    chk({tag, "_total"}, GW'(bus.total_lines_o), GW'(exp_total));
    @(negedge clk);
    chk({tag, "_done_width"}, GW'(bus.done), GW'(0));
    if (intrude) begin
      extra = 0;
      for (int i = 0; i < 70; i++) begin
        @(negedge clk);
        if (bus.done) extra++;
      end
      chk({tag, "_extra_done"}, GW'(extra), GW'(0));
      chk({tag, "_grid_kept"}, bus.grid_o, eg);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    grid_t g;
    grid_t eg;
    int    n;
    int    dcount;
    tests     = 0;
    fails     = 0;
    exp_total = 0;
    bus.start  = 1'b0;
    bus.grid_i = '0;
    rst_n      = 1'b0;

    // Directed table.
    for (int t = 0; t < 4; t++) begin
      tbl[t].g = '0; tbl[t].eg = '0; tbl[t].lines = 0;
    end
    for (int c = 0; c < COLS; c++) tbl[1].g[21][c] = 3'b100;
    tbl[1].g[20][0] = 3'b001;
    tbl[1].eg[21][0] = 3'b001;
    tbl[1].lines = 1;
    for (int c = 0; c < COLS; c++) begin
      tbl[2].g[21][c] = 3'b010;
      tbl[2].g[19][c] = 3'b010;
    end
    tbl[2].g[20][5] = 3'b111;
    tbl[2].g[18][9] = 3'b110;
    tbl[2].eg[21][5] = 3'b111;
    tbl[2].eg[20][9] = 3'b110;
    tbl[2].lines = 2;
    for (int c = 0; c < COLS; c++) begin
      for (int rr = 18; rr < 22; rr++) tbl[3].g[rr][c] = 3'(((c + rr) % 7) + 1);
      tbl[3].g[0][c] = 3'(((c + 3) % 7) + 1);
    end
    tbl[3].lines = 5;

    repeat (3) @(negedge clk);
    chk("reset_busy", GW'(bus.busy), GW'(0));
    chk("reset_done", GW'(bus.done), GW'(0));
    chk("reset_grid", bus.grid_o, '0);
    rst_n = 1'b1;

    // Make state non-trivial, then reset mid-SCAN.
    run_pass("pre", tbl[1].g, tbl[1].eg, 1, 1'b0, '0);
    @(negedge clk);
    bus.grid_i = tbl[3].g;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", GW'(bus.busy), GW'(0));
    chk("rst_done", GW'(bus.done), GW'(0));
    chk("rst_lines", GW'(bus.lines_o), GW'(0));
    chk("rst_total", GW'(bus.total_lines_o), GW'(0));
    chk("rst_grid", bus.grid_o, '0);
    exp_total = 0;
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("rst_no_done", GW'(dcount), GW'(0));

    for (int t = 0; t < 4; t++) begin
      run_pass($sformatf("tbl%0d", t), tbl[t].g, tbl[t].eg, tbl[t].lines, 1'b0, '0);
    end

    // Start while busy must be ignored.
    run_pass("intrude", tbl[1].g, tbl[1].eg, 1, 1'b1, tbl[3].g);

    // Random grids against the reference model.
    for (int t = 0; t < 20; t++) begin
      for (int rr = 0; rr < ROWS; rr++) begin
        int mode;
        mode = $urandom_range(0, 2);
        for (int c = 0; c < COLS; c++) begin
          case (mode)
            0:       g[rr][c] = 3'($urandom_range(1, 7));
            1:       g[rr][c] = 3'($urandom_range(0, 7));
            default: g[rr][c] = '0;
          endcase
        end
      end
      ref_compact(g, eg, n);
      run_pass($sformatf("rnd%0d", t), g, eg, n, 1'b0, '0);
    end

    // Saturation through a backdoor on the running total.
    @(negedge clk);
    force bus.total_lines_o = 16'd65534;
    @(negedge clk);
    release bus.total_lines_o;
    exp_total = 65534;
    g = tbl[3].g;
    g[0] = '0;
    run_pass("sat1", g, '0, 4, 1'b0, '0);
    run_pass("sat2", g, '0, 4, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
